// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU and program loader) in front of a single-port 16x8 RAM
// with registered read: serialises accesses and returns read data with rvalid.
module mem_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_load,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  logic [1:0]        state;
  logic              owner;
  logic              last_owner;
  logic              pick_ldr;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Winner is only consumed in IDLE; on a tie round-robin favours whoever did not go last.
  always_comb begin
    pick_ldr = ldr_req;
    if (cpu_req && ldr_req) begin
      pick_ldr = (ARB_MODE == 0) ? (last_owner == OWN_CPU) : 1'b0;
    end
    win_we    = pick_ldr ? ldr_we    : cpu_we;
    win_addr  = pick_ldr ? ldr_addr  : cpu_addr;
    win_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_LDR;
      mem_load   <= 1'b0;
      mem_oe     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || ldr_req) begin
            state      <= S_ACCESS;
            owner      <= pick_ldr;
            last_owner <= pick_ldr;
            mem_addr   <= win_addr;
            mem_wdata  <= win_wdata;
            mem_load   <= win_we;
            mem_oe     <= ~win_we;
            cpu_gnt    <= ~pick_ldr;
            ldr_gnt    <= pick_ldr;
          end else begin
            mem_load <= 1'b0;
            mem_oe   <= 1'b0;
          end
        end
        // RAM commits the write or latches read data at the end of this cycle
        S_ACCESS: begin
          cpu_gnt  <= 1'b0;
          ldr_gnt  <= 1'b0;
          mem_load <= 1'b0;
          if (mem_load) begin
            state  <= S_IDLE;
            mem_oe <= 1'b0;
          end else begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          mem_oe <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          mem_load <= 1'b0;
          mem_oe   <= 1'b0;
          cpu_gnt  <= 1'b0;
          ldr_gnt  <= 1'b0;
        end
      endcase
    end
  end

  // RAM output is only trusted while RESP holds oe high; elsewhere rdata is forced to zero.
  always_comb begin
    cpu_rvalid = (state == S_RESP) && (owner == OWN_CPU);
    ldr_rvalid = (state == S_RESP) && (owner == OWN_LDR);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    ldr_rdata  = ldr_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances share stimulus, each
// drives its own RAM model and is compared every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          ldr_req = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;

  logic          cpu_gnt [2], cpu_rvalid [2], ldr_gnt [2], ldr_rvalid [2];
  logic          mem_load [2], mem_oe [2];
  logic [DW-1:0] cpu_rdata [2], ldr_rdata [2], mem_wdata [2];
  logic [AW-1:0] mem_addr [2];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] ram [16];
    logic [DW-1:0] dout;
    wire  [DW-1:0] mem_rdata = mem_oe[g] ? dout : 'z;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(g)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]), .cpu_rdata(cpu_rdata[g]),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt[g]), .ldr_rvalid(ldr_rvalid[g]), .ldr_rdata(ldr_rdata[g]),
      .mem_load(mem_load[g]), .mem_oe(mem_oe[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata)
    );

    // Single-port RAM: synchronous write, registered read, tri-stated output
    always @(posedge clk) begin
      if (mem_load[g]) ram[mem_addr[g]] <= mem_wdata[g];
      if (mem_oe[g])   dout <= ram[mem_addr[g]];
    end
  end

  // Transaction-level reference: each accepted request owns one ACCESS cycle (index acc_at),
  // reads add one response cycle; the arbiter is free again once that access has drained.
  int            cyc = 0;
  int            acc_at [2] = '{-100, -100};
  int            free_at [2] = '{0, 0};
  logic          last_ldr [2] = '{1'b1, 1'b1};
  logic          r_who [2], r_we [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wdata [2];
  logic [DW-1:0] ram_ref [2][16];

  function automatic logic pick_ldr(int mode, logic last_l, logic c, logic l);
    if (c && l) return (mode == 0) ? !last_l : 1'b0;
    return l;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        acc_at[m]   <= -100;
        free_at[m]  <= 0;
        last_ldr[m] <= 1'b1;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (cyc >= free_at[m] && (cpu_req || ldr_req)) begin
          acc_at[m] <= cyc + 1;
          if (pick_ldr(m, last_ldr[m], cpu_req, ldr_req)) begin
            r_who[m] <= 1'b1; r_we[m] <= ldr_we; r_addr[m] <= ldr_addr; r_wdata[m] <= ldr_wdata;
            free_at[m]  <= cyc + (ldr_we ? 2 : 3);
            last_ldr[m] <= 1'b1;
            if (ldr_we) ram_ref[m][ldr_addr] <= ldr_wdata;
          end else begin
            r_who[m] <= 1'b0; r_we[m] <= cpu_we; r_addr[m] <= cpu_addr; r_wdata[m] <= cpu_wdata;
            free_at[m]  <= cyc + (cpu_we ? 2 : 3);
            last_ldr[m] <= 1'b0;
            if (cpu_we) ram_ref[m][cpu_addr] <= cpu_wdata;
          end
        end
      end
    end
  end

  logic        acc_c [2], rsp_c [2], busy_c [2];
  logic [33:0] expv [2], obs [2];

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      acc_c[m]  = (cyc == acc_at[m]);
      rsp_c[m]  = (cyc == acc_at[m] + 1) && !r_we[m];
      busy_c[m] = acc_c[m] || rsp_c[m];
      expv[m] = {acc_c[m] && !r_who[m], rsp_c[m] && !r_who[m],
                 (rsp_c[m] && !r_who[m]) ? ram_ref[m][r_addr[m]] : 8'h00,
                 acc_c[m] && r_who[m], rsp_c[m] && r_who[m],
                 (rsp_c[m] && r_who[m]) ? ram_ref[m][r_addr[m]] : 8'h00,
                 acc_c[m] && r_we[m], (acc_c[m] && !r_we[m]) || rsp_c[m],
                 busy_c[m] ? r_addr[m] : 4'h0, busy_c[m] ? r_wdata[m] : 8'h00};
      obs[m] = {cpu_gnt[m], cpu_rvalid[m], cpu_rdata[m], ldr_gnt[m], ldr_rvalid[m], ldr_rdata[m],
                mem_load[m], mem_oe[m], busy_c[m] ? mem_addr[m] : 4'h0,
                busy_c[m] ? mem_wdata[m] : 8'h00};
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd5;
    @(posedge clk); #1;
    vectors++;
    if (cpu_gnt[0] !== 1'b1 || cpu_gnt[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_gnt: got %b%b want 11", cpu_gnt[0], cpu_gnt[1]);
    end
    cpu_req = 1'b0; rst_n = 1'b0; #1;
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if ({cpu_gnt[m], cpu_rvalid[m], cpu_rdata[m], ldr_gnt[m], ldr_rvalid[m], ldr_rdata[m],
           mem_load[m], mem_oe[m], mem_addr[m], mem_wdata[m]} !== 34'h0) begin
        miscompares++;
        $display("FAIL reset_async dut%0d: got %h want 0", m, obs[m]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL reset_after cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
    end
  endtask

  task automatic test_loader_fill();
    int gc0 = 0, gc1 = 0, a = 0;
    logic g, seen;
    @(posedge clk); #1; ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'd0; ldr_wdata = 8'h00;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL fill cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
      g = ldr_gnt[0];
      if (ldr_gnt[0]) gc0++;
      if (ldr_gnt[1]) gc1++;
      @(posedge clk); #1;
      if (g) begin
        a++;
        if (a == 16) ldr_req = 1'b0;
        else begin ldr_addr = 4'(a); ldr_wdata = 8'(a); end
      end
    end
    vectors++;
    if (gc0 != 16 || gc1 != 16) begin
      miscompares++;
      $display("FAIL fill_gnt_count: got %0d/%0d want 16/16", gc0, gc1);
    end
    for (int k = 0; k < 16; k++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'(k); seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); vectors++;
        if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
          miscompares++;
          $display("FAIL readback cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
        end
        g = cpu_gnt[0];
        if (cpu_rvalid[0]) begin
          seen = 1'b1; vectors++;
          if (cpu_rdata[0] !== 8'(k)) begin
            miscompares++;
            $display("FAIL readback_data addr=%0d: got %h want %h", k, cpu_rdata[0], 8'(k));
          end
        end
        @(posedge clk); #1;
        if (g) cpu_req = 1'b0;
      end
      vectors++;
      if (seen !== 1'b1) begin
        miscompares++;
        $display("FAIL readback_timeout addr=%0d: got no rvalid want rvalid", k);
      end
    end
  endtask

  task automatic test_cpu_write_read();
    int ng = 0, nl = 0;
    logic g, seen = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL cpu_write cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
      g = cpu_gnt[0];
      if (cpu_gnt[0]) ng++;
      if (mem_load[0]) begin
        nl++; vectors++;
        if (mem_addr[0] !== 4'd3 || mem_wdata[0] !== 8'hA5) begin
          miscompares++;
          $display("FAIL cpu_write_pins: got addr %h data %h want 3 a5", mem_addr[0], mem_wdata[0]);
        end
      end
      @(posedge clk); #1;
      if (g) cpu_req = 1'b0;
    end
    vectors++;
    if (ng != 1 || nl != 1) begin
      miscompares++;
      $display("FAIL cpu_write_pulses: got gnt %0d load %0d want 1 1", ng, nl);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL cpu_read cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
      g = cpu_gnt[0];
      if (cpu_rvalid[0]) begin
        seen = 1'b1; vectors++;
        if (cpu_rdata[0] !== 8'hA5) begin
          miscompares++;
          $display("FAIL cpu_read_data: got %h want a5", cpu_rdata[0]);
        end
      end
      @(posedge clk); #1;
      if (g) cpu_req = 1'b0;
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL cpu_read_timeout: got no rvalid want rvalid");
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq0 = '0, seq1 = '0;
    int n0 = 0, n1 = 0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd1;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'd2;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL rr cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
      if (cpu_gnt[0] || ldr_gnt[0]) begin seq0 = {seq0[2:0], ldr_gnt[0]}; n0++; end
      if (cpu_gnt[1] || ldr_gnt[1]) begin seq1 = {seq1[2:0], ldr_gnt[1]}; n1++; end
      @(posedge clk); #1;
      if (i == 11) begin cpu_req = 1'b0; ldr_req = 1'b0; end
    end
    vectors++;
    if (n0 != 4 || seq0 !== 4'b0101) begin
      miscompares++;
      $display("FAIL rr_order: got %0d grants seq %b want 4 seq 0101", n0, seq0);
    end
    vectors++;
    if (n1 != 4 || seq1 !== 4'b0000) begin
      miscompares++;
      $display("FAIL fixed_tie_order: got %0d grants seq %b want 4 seq 0000", n1, seq1);
    end
  endtask

  task automatic test_fixed_priority();
    int lg = 0, cg = 0;
    logic gc, gl, seen = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'($urandom);
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'($urandom); ldr_wdata = 8'($urandom);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL fixed cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
      if (ldr_gnt[1]) lg++;
      gc = cpu_gnt[1];
      if (gc) cg++;
      @(posedge clk); #1;
      if (gc) cpu_addr = 4'($urandom);
    end
    vectors++;
    if (lg != 0 || cg != 10) begin
      miscompares++;
      $display("FAIL fixed_starve: got ldr %0d cpu %0d grants want 0 10", lg, cg);
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL fixed_release cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
      gl = ldr_gnt[1];
      if (gl) seen = 1'b1;
      @(posedge clk); #1;
      if (gl) ldr_req = 1'b0;
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL fixed_release_gnt: got no ldr_gnt want ldr_gnt");
    end
  endtask

  task automatic test_addr_change();
    logic seen = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL chg_write cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if ((mem_load[m] & mem_oe[m]) !== 1'b0) begin
          miscompares++;
          $display("FAIL load_oe_excl dut%0d: got load&oe=1 want 0", m);
        end
      end
      if (cpu_gnt[0]) begin cpu_addr = 4'd8; cpu_wdata = 8'hFF; cpu_req = 1'b0; end
      if (i == 3) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7; end
      if (cpu_rvalid[0]) begin
        seen = 1'b1; vectors++;
        if (cpu_rdata[0] !== 8'h3C) begin
          miscompares++;
          $display("FAIL chg_read_data: got %h want 3c", cpu_rdata[0]);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL chg_read_timeout: got no rvalid want rvalid");
    end
  endtask

  task automatic test_random();
    logic gc, gl;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL random cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
      gc = cpu_gnt[0];
      gl = ldr_gnt[0];
      @(posedge clk); #1;
      if ((cpu_req && gc) || (!cpu_req && $urandom_range(0, 2) == 0)) begin
        cpu_req = cpu_req ? 1'($urandom) : 1'b1;
        cpu_we = 1'($urandom); cpu_addr = 4'($urandom); cpu_wdata = 8'($urandom);
      end
      if ((ldr_req && gl) || (!ldr_req && $urandom_range(0, 2) == 0)) begin
        ldr_req = ldr_req ? 1'($urandom) : 1'b1;
        ldr_we = 1'($urandom); ldr_addr = 4'($urandom); ldr_wdata = 8'($urandom);
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (4) begin
      @(negedge clk); vectors++;
      if (obs[0] !== expv[0] || obs[1] !== expv[1]) begin
        miscompares++;
        $display("FAIL random_drain cyc=%0d got %h/%h want %h/%h", cyc, obs[0], obs[1], expv[0], expv[1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_loader_fill();
    test_cpu_write_read();
    test_round_robin();
    test_fixed_priority();
    test_addr_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
